// File: rtl/ifetch_if.sv
// Fetch-unit bus bundle: PC address handshake, instruction memory
// port and decode-side instruction handshake.
interface ifetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              pc_valid;
  logic [ADDR_W-1:0] pc_addr;
  logic              pc_ready;
  logic              flush;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic [ADDR_W-1:0] inst_npc;
  logic              inst_ready;

  modport master (
    output pc_valid, pc_addr, flush,
    output mem_ack, mem_rdata, inst_ready,
    input  pc_ready, mem_req, mem_addr,
    input  inst_valid, inst, inst_pc, inst_npc
  );

  modport slave (
    input  pc_valid, pc_addr, flush,
    input  mem_ack, mem_rdata, inst_ready,
    output pc_ready, mem_req, mem_addr,
    output inst_valid, inst, inst_pc, inst_npc
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch: one outstanding memory read at a time, results
// buffered in a small FIFO towards decode; flush voids everything.
module ifetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input logic    clk,
  input logic    rst,
  ifetch_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN
  } state_t;

  state_t            state;
  logic              req;
  logic [ADDR_W-1:0] req_addr;

  logic [DATA_W-1:0] q_data [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count;

  logic accept;
  logic push;
  logic pop;
  logic empty;

  assign empty = (count == '0);

  assign bus.pc_ready = (state == IDLE) &&
                        (bus.flush || count < FULL);

  assign accept = bus.pc_valid && bus.pc_ready;
  assign push   = (state == BUSY) && bus.mem_ack &&
                  !bus.flush;
  assign pop    = !empty && bus.inst_ready && !bus.flush;

  assign bus.mem_req  = req;
  assign bus.mem_addr = req_addr;

  assign bus.inst_valid = !empty;
  assign bus.inst     = empty ? '0 : q_data[rd_ptr];
  assign bus.inst_pc  = empty ? '0 : q_pc[rd_ptr];
  assign bus.inst_npc = empty ? '0 :
                        q_pc[rd_ptr] + ADDR_W'(4);

  // Request FSM; a flush mid-request waits out the ack in DRAIN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req      <= 1'b0;
      req_addr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state    <= BUSY;
            req      <= 1'b1;
            req_addr <= bus.pc_addr & ~ADDR_W'(3);
          end
        end
        BUSY: begin
          if (bus.mem_ack) begin
            state <= IDLE;
            req   <= 1'b0;
          end else if (bus.flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.mem_ack) begin
            state <= IDLE;
            req   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; flush wins over push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are only visible through count
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= bus.mem_rdata;
      q_pc[wr_ptr]   <= req_addr;
    end
  end
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus a random run,
// all checked against a queue-based model of the fetch unit.
module tb_ifetch_unit;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   mem_lat = 0;
  int   wait_cnt = 0;

  ifetch_if #(.ADDR_W(32), .DATA_W(32)) bus();

  ifetch_unit #(
    .ADDR_W(32),
    .DATA_W(32),
    .DEPTH (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // memory: acks after mem_lat extra cycles with random data
  always @(posedge clk) begin
    #1;
    bus.mem_ack = 1'b0;
    if (bus.mem_req) begin
      if (wait_cnt >= mem_lat) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = $urandom;
        wait_cnt      = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // reference model: expected FIFO contents and outstanding fetch
  logic [31:0] m_pc[$];
  logic [31:0] m_dat[$];
  bit          m_out = 0;
  bit          m_drop = 0;
  logic [31:0] m_addr = '0;
  bit          m_ack;
  bit          m_acc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc.delete();
      m_dat.delete();
      m_out  = 0;
      m_drop = 0;
      m_addr = '0;
    end else begin
      m_ack = bus.mem_ack && m_out;
      m_acc = bus.pc_valid && !m_out &&
              (bus.flush || m_pc.size() < DEPTH);
      if (bus.flush) begin
        m_pc.delete();
        m_dat.delete();
      end else begin
        if (bus.inst_ready && m_pc.size() > 0) begin
          void'(m_pc.pop_front());
          void'(m_dat.pop_front());
        end
        if (m_ack && !m_drop) begin
          m_pc.push_back(m_addr);
          m_dat.push_back(bus.mem_rdata);
        end
      end
      if (m_ack) begin
        m_out  = 0;
        m_drop = 0;
      end else if (bus.flush && m_out) begin
        m_drop = 1;
      end
      if (m_acc) begin
        m_out  = 1;
        m_drop = 0;
        m_addr = {bus.pc_addr[31:2], 2'b00};
      end
    end
  end

  function automatic bit exp_ready();
    return !m_out && (bus.flush || m_pc.size() < DEPTH);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.mem_req && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL wait_idle: mem_req still 1 after %0d cycles, need 0", n);
    end
  endtask

  task automatic fetch_one(input logic [31:0] a);
    int n = 0;
    bus.pc_valid = 1'b1;
    bus.pc_addr  = a;
    @(negedge clk);
    while (!bus.pc_ready && n < 50) begin
      step();
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL fetch_accept: pc_ready=0 for %0d cycles, need 1", n);
    end
    step();
    bus.pc_valid = 1'b0;
    wait_idle();
  endtask

  task automatic drain_all();
    bus.inst_ready = 1'b1;
    repeat (DEPTH + 2) step();
    bus.inst_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    total += 6;
    if (bus.pc_ready !== 1'b1) begin
      bad++; $display("FAIL rst_pc_ready: got %b need 1", bus.pc_ready);
    end
    if (bus.mem_req !== 1'b0) begin
      bad++; $display("FAIL rst_mem_req: got %b need 0", bus.mem_req);
    end
    if (bus.mem_addr !== 32'h0) begin
      bad++; $display("FAIL rst_mem_addr: got %h need 0", bus.mem_addr);
    end
    if (bus.inst_valid !== 1'b0) begin
      bad++; $display("FAIL rst_inst_valid: got %b need 0", bus.inst_valid);
    end
    if (bus.inst !== 32'h0 || bus.inst_pc !== 32'h0) begin
      bad++; $display("FAIL rst_inst: got %h/%h need 0/0", bus.inst, bus.inst_pc);
    end
    if (bus.inst_npc !== 32'h0) begin
      bad++; $display("FAIL rst_npc: got %h need 0", bus.inst_npc);
    end
    step();
    rst = 1'b0;
    mem_lat = 10;
    bus.pc_valid = 1'b1;
    bus.pc_addr  = 32'h100;
    step();
    bus.pc_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.mem_req !== 1'b1) begin
      bad++; $display("FAIL busy_req: got %b need 1", bus.mem_req);
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus.mem_req !== 1'b0) begin
      bad++; $display("FAIL async_drop: got %b need 0", bus.mem_req);
    end
    @(negedge clk);
    rst = 1'b0;
    mem_lat = 0;
    step();
    @(negedge clk);
    total += 3;
    if (bus.pc_ready !== 1'b1) begin
      bad++; $display("FAIL post_rst_ready: got %b need 1", bus.pc_ready);
    end
    if (bus.inst_valid !== 1'b0) begin
      bad++; $display("FAIL post_rst_valid: got %b need 0", bus.inst_valid);
    end
    if (bus.mem_req !== 1'b0) begin
      bad++; $display("FAIL post_rst_req: got %b need 0", bus.mem_req);
    end
    step();
  endtask

  task automatic test_stream();
    logic [31:0] addrs [4];
    int idx = 0;
    int got = 0;
    bit prev_ack = 0;
    bit acc;
    for (int i = 0; i < 4; i++) addrs[i] = 32'(4 * i);
    mem_lat = 0;
    bus.inst_ready = 1'b1;
    bus.pc_valid = 1'b1;
    bus.pc_addr  = addrs[0];
    for (int c = 0; c < 60 && got < 4; c++) begin
      @(negedge clk);
      total++;
      if (bus.inst_valid !== prev_ack) begin
        bad++;
        $display("FAIL stream_timing: inst_valid=%b need %b", bus.inst_valid, prev_ack);
      end
      if (bus.inst_valid === 1'b1) begin
        total += 3;
        if (bus.inst_pc !== addrs[got]) begin
          bad++;
          $display("FAIL stream_pc: got %h need %h", bus.inst_pc, addrs[got]);
        end
        if (bus.inst_npc !== addrs[got] + 32'd4) begin
          bad++;
          $display("FAIL stream_npc: got %h need %h", bus.inst_npc, addrs[got] + 32'd4);
        end
        if (m_dat.size() == 0 || bus.inst !== m_dat[0]) begin
          bad++;
          $display("FAIL stream_data: got %h", bus.inst);
        end
        got++;
      end
      prev_ack = bus.mem_ack && bus.mem_req;
      acc = bus.pc_valid && bus.pc_ready;
      step();
      if (acc) begin
        idx++;
        if (idx < 4) bus.pc_addr = addrs[idx];
        else bus.pc_valid = 1'b0;
      end
    end
    bus.pc_valid = 1'b0;
    total++;
    if (got != 4) begin
      bad++; $display("FAIL stream_count: got %0d need 4", got);
    end
    drain_all();
  endtask

  task automatic test_full();
    bus.inst_ready = 1'b0;
    mem_lat = $urandom_range(0, 2);
    for (int k = 0; k < 4; k++) fetch_one(32'h200 + 32'(4 * k));
    bus.pc_valid = 1'b1;
    bus.pc_addr  = 32'h210;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total += 3;
      if (bus.pc_ready !== 1'b0) begin
        bad++; $display("FAIL full_ready: got %b need 0", bus.pc_ready);
      end
      if (bus.mem_req !== 1'b0) begin
        bad++; $display("FAIL full_req: got %b need 0", bus.mem_req);
      end
      if (bus.inst_pc !== 32'h200) begin
        bad++; $display("FAIL full_head: got %h need 200", bus.inst_pc);
      end
      step();
    end
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    @(negedge clk);
    total += 2;
    if (bus.pc_ready !== 1'b1) begin
      bad++; $display("FAIL pop_ready: got %b need 1", bus.pc_ready);
    end
    if (bus.inst_pc !== 32'h204) begin
      bad++; $display("FAIL pop_head: got %h need 204", bus.inst_pc);
    end
    step();
    bus.pc_valid = 1'b0;
    wait_idle();
    bus.inst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total += 2;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h204 + 32'(4 * k)) begin
        bad++;
        $display("FAIL full_order: got %b/%h need 1/%h", bus.inst_valid, bus.inst_pc, 32'h204 + 32'(4 * k));
      end
      if (m_dat.size() == 0 || bus.inst !== m_dat[0]) begin
        bad++; $display("FAIL full_data: got %h", bus.inst);
      end
      step();
    end
    drain_all();
  endtask

  task automatic test_flush_drain();
    int n = 0;
    bus.inst_ready = 1'b0;
    mem_lat = 0;
    fetch_one(32'h300);
    fetch_one(32'h304);
    mem_lat = 4;
    bus.pc_valid = 1'b1;
    bus.pc_addr  = 32'h308;
    step();
    bus.pc_valid = 1'b0;
    step();
    bus.flush    = 1'b1;
    bus.pc_valid = 1'b1;
    bus.pc_addr  = 32'h40;
    @(negedge clk);
    total++;
    if (bus.pc_ready !== 1'b0) begin
      bad++; $display("FAIL busy_flush_ready: got %b need 0", bus.pc_ready);
    end
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    total += 2;
    if (bus.inst_valid !== 1'b0) begin
      bad++; $display("FAIL flush_empty: got %b need 0", bus.inst_valid);
    end
    if (bus.mem_req !== 1'b1) begin
      bad++; $display("FAIL drain_req: got %b need 1", bus.mem_req);
    end
    while (!bus.pc_ready && n < 20) begin
      total++;
      if (bus.mem_req !== 1'b1) begin
        bad++; $display("FAIL drain_hold: got %b need 1", bus.mem_req);
      end
      step();
      @(negedge clk);
      n++;
    end
    total += 2;
    if (n >= 20) begin
      bad++; $display("FAIL drain_timeout: pc_ready=0 after %0d cycles", n);
    end
    if (bus.inst_valid !== 1'b0) begin
      bad++; $display("FAIL drain_discard: got %b need 0", bus.inst_valid);
    end
    step();
    bus.pc_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40) begin
      bad++;
      $display("FAIL redirect_issue: got %b/%h need 1/40", bus.mem_req, bus.mem_addr);
    end
    step();
    wait_idle();
    bus.inst_ready = 1'b1;
    @(negedge clk);
    total += 2;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h40) begin
      bad++;
      $display("FAIL redirect_head: got %b/%h need 1/40", bus.inst_valid, bus.inst_pc);
    end
    if (m_dat.size() == 0 || bus.inst !== m_dat[0]) begin
      bad++; $display("FAIL redirect_data: got %h", bus.inst);
    end
    step();
    @(negedge clk);
    total++;
    if (bus.inst_valid !== 1'b0) begin
      bad++; $display("FAIL redirect_only: got %b need 0", bus.inst_valid);
    end
    mem_lat = 0;
    drain_all();
  endtask

  task automatic test_flush_idle();
    bus.inst_ready = 1'b0;
    mem_lat = 0;
    for (int k = 0; k < 4; k++) fetch_one($urandom);
    bus.flush    = 1'b1;
    bus.pc_valid = 1'b1;
    bus.pc_addr  = 32'h80;
    @(negedge clk);
    total++;
    if (bus.pc_ready !== 1'b1) begin
      bad++; $display("FAIL idle_flush_ready: got %b need 1", bus.pc_ready);
    end
    step();
    bus.flush    = 1'b0;
    bus.pc_valid = 1'b0;
    @(negedge clk);
    total += 2;
    if (bus.inst_valid !== 1'b0) begin
      bad++; $display("FAIL idle_flush_empty: got %b need 0", bus.inst_valid);
    end
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h80) begin
      bad++;
      $display("FAIL idle_flush_issue: got %b/%h need 1/80", bus.mem_req, bus.mem_addr);
    end
    step();
    wait_idle();
    @(negedge clk);
    total++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h80) begin
      bad++;
      $display("FAIL idle_flush_head: got %b/%h need 1/80", bus.inst_valid, bus.inst_pc);
    end
    drain_all();
  endtask

  task automatic test_align();
    bus.inst_ready = 1'b0;
    mem_lat = $urandom_range(0, 3);
    bus.pc_valid = 1'b1;
    bus.pc_addr  = 32'h13;
    step();
    bus.pc_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.mem_addr !== 32'h10) begin
      bad++; $display("FAIL align_addr: got %h need 10", bus.mem_addr);
    end
    step();
    wait_idle();
    fetch_one(32'hFFFF_FFFC);
    @(negedge clk);
    total += 2;
    if (bus.inst_pc !== 32'h10) begin
      bad++; $display("FAIL align_pc: got %h need 10", bus.inst_pc);
    end
    if (bus.inst_npc !== 32'h14) begin
      bad++; $display("FAIL align_npc: got %h need 14", bus.inst_npc);
    end
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    @(negedge clk);
    total += 2;
    if (bus.inst_pc !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL wrap_pc: got %h need fffffffc", bus.inst_pc);
    end
    if (bus.inst_npc !== 32'h0) begin
      bad++; $display("FAIL wrap_npc: got %h need 0", bus.inst_npc);
    end
    drain_all();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bus.pc_valid   = ($urandom % 3) != 0;
      bus.pc_addr    = ($urandom % 4 == 0) ? 32'hFFFF_FFF0 | ($urandom % 16) : $urandom;
      bus.flush      = ($urandom % 12) == 0;
      bus.inst_ready = ($urandom % 2) == 0;
      if (!bus.mem_req) mem_lat = $urandom_range(0, 3);
      @(negedge clk);
      total += 4;
      if (bus.pc_ready !== exp_ready()) begin
        bad++; $display("FAIL rnd_ready: got %b need %b", bus.pc_ready, exp_ready());
      end
      if (bus.mem_req !== m_out) begin
        bad++; $display("FAIL rnd_req: got %b need %b", bus.mem_req, m_out);
      end
      if (bus.mem_addr !== m_addr) begin
        bad++; $display("FAIL rnd_addr: got %h need %h", bus.mem_addr, m_addr);
      end
      if (bus.inst_valid !== (m_pc.size() > 0)) begin
        bad++; $display("FAIL rnd_valid: got %b need %0d", bus.inst_valid, m_pc.size());
      end
      if (m_pc.size() > 0) begin
        total++;
        if (bus.inst_pc !== m_pc[0] || bus.inst !== m_dat[0] ||
            bus.inst_npc !== m_pc[0] + 32'd4) begin
          bad++;
          $display("FAIL rnd_head: got %h/%h/%h need %h/%h/%h", bus.inst_pc, bus.inst, bus.inst_npc, m_pc[0], m_dat[0], m_pc[0] + 32'd4);
        end
      end
      step();
    end
    bus.pc_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  initial begin
    bus.pc_valid   = 1'b0;
    bus.pc_addr    = '0;
    bus.flush      = 1'b0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = '0;
    bus.inst_ready = 1'b0;
    test_reset();
    test_stream();
    test_full();
    test_flush_drain();
    test_flush_idle();
    test_align();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
